// File: rtl/tty_pkg.sv
// ---------------------------------------------------------------------------
// tty_pkg -- shared definitions for the text-terminal write controller.
//
// Contents:
//   COLS_DEFAULT / ROWS_DEFAULT  default text geometry
//   CH_*                         control and printable-range character codes
//   tty_state_t                  controller FSM states (IDLE, EXEC, CLEAR)
//   tty_cmd_t                    decoded action for the character in hand
//   decode_char()                character -> action
//   phys_row()                   logical row -> physical RAM row (ring offset)
// ---------------------------------------------------------------------------
package tty_pkg;

    localparam int COLS_DEFAULT = 80;
    localparam int ROWS_DEFAULT = 30;

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_TILDE = 8'h7E;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        CLEAR
    } tty_state_t;

    typedef enum logic [2:0] {
        CMD_NOP,
        CMD_PRINT,
        CMD_LF,
        CMD_CR,
        CMD_BS
    } tty_cmd_t;

    // Backspace at column 0 has nothing to erase, so it decodes as a no-op.
    function automatic tty_cmd_t decode_char(input logic [7:0] ch,
                                             input logic       at_col0);
        tty_cmd_t cmd;
        cmd = CMD_NOP;
        if (ch >= CH_SPACE && ch <= CH_TILDE) cmd = CMD_PRINT;
        else if (ch == CH_LF)                 cmd = CMD_LF;
        else if (ch == CH_CR)                 cmd = CMD_CR;
        else if (ch == CH_BS && !at_col0)     cmd = CMD_BS;
        return cmd;
    endfunction

    // Both operands are below rows, so a single conditional subtract wraps.
    function automatic logic [4:0] phys_row(input logic [4:0] row,
                                            input logic [4:0] base,
                                            input int         rows);
        logic [5:0] sum;
        sum = {1'b0, row} + {1'b0, base};
        if (sum >= 6'(rows)) sum = sum - 6'(rows);
        return sum[4:0];
    endfunction

endpackage

// File: rtl/tty_char_fifo.sv
// ---------------------------------------------------------------------------
// tty_char_fifo -- small synchronous character FIFO.
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   synchronous active-low reset (pointers and count only)
//   push   in   write din this cycle (ignored while full)
//   pop    in   advance read pointer this cycle (ignored while empty)
//   din    in   WIDTH-bit write data
//   dout   out  head-of-queue data (valid while !empty)
//   full   out  count == DEPTH, from the registered count
//   empty  out  count == 0, from the registered count
// ---------------------------------------------------------------------------
module tty_char_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             push_ok;
    logic             pop_ok;

    // A push while full is dropped even if a pop frees a slot the same cycle,
    // so full never depends on the pop decision.
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);
        end
    end

    // NOTE: storage has no reset; empty/count guard every read, so stale data is never seen.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/tty_write_ctrl.sv
// ---------------------------------------------------------------------------
// tty_write_ctrl -- CPU character stream to text-RAM write controller.
//
// Characters written by the CPU are queued, then executed one at a time:
// printable codes are stored at the cursor, CR/LF/BS move the cursor, and
// other codes are ignored. The text RAM is a ring of ROWS physical rows;
// scroll_row is the physical row shown as logical row 0.
//
// Build option:
//   TTY_SCROLL_EN  defined   -> newline on the last row clears the top
//                               physical row and advances scroll_row.
//                  undefined -> newline on the last row wraps the cursor
//                               to row 0; scroll_row stays 0.
//
// Ports:
//   clk_50mhz   in   sole clock, rising edge
//   rst_n       in   synchronous active-low reset
//   Memwrite    in   CPU write strobe, one character per high cycle
//   BUS[31:0]   in   CPU data, character in BUS[7:0]
//   ttyWFlag    out  FIFO full, CPU must hold off
//   ttywrite    out  text-RAM write enable, one pulse per cell
//   ttyaddr     out  text-RAM address = phys_row*COLS + col
//   ttydata     out  text-RAM write data
//   cur_x/cur_y out  logical cursor column/row
//   scroll_row  out  physical row displayed as logical row 0
// ---------------------------------------------------------------------------
module tty_write_ctrl
    import tty_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int COLS       = COLS_DEFAULT,
    parameter int ROWS       = ROWS_DEFAULT
) (
    input  logic        clk_50mhz,
    input  logic        rst_n,
    input  logic        Memwrite,
    input  logic [31:0] BUS,
    output logic        ttyWFlag,
    output logic        ttywrite,
    output logic [11:0] ttyaddr,
    output logic [7:0]  ttydata,
    output logic [6:0]  cur_x,
    output logic [4:0]  cur_y,
    output logic [4:0]  scroll_row
);

    tty_state_t state;
    tty_state_t state_next;
    tty_cmd_t   cmd;

    logic [7:0] char_q;
    logic [7:0] fifo_dout;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_pop;
    logic       newline;
    logic       last_row;
    logic [4:0] cur_phys;
    logic [4:0] wr_row;
    logic [6:0] wr_col;
    logic       unused_bus;

    assign unused_bus = ^BUS[31:8];

    tty_char_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk_50mhz),
        .rst_n (rst_n),
        .push  (Memwrite),
        .pop   (fifo_pop),
        .din   (BUS[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign ttyWFlag = fifo_full;

    assign cmd      = decode_char(char_q, cur_x == '0);
    assign newline  = (cmd == CMD_LF) ||
                      (cmd == CMD_PRINT && cur_x == 7'(COLS-1));
    assign last_row = (cur_y == 5'(ROWS-1));
    assign cur_phys = phys_row(cur_y, scroll_row, ROWS);

`ifdef TTY_SCROLL_EN
    logic [6:0] clear_col;
    logic       clear_last;
    assign clear_last = (clear_col == 7'(COLS-1));
`endif

    // ---------------- state register ----------------
    always_ff @(posedge clk_50mhz) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (!fifo_empty) state_next = EXEC;
            EXEC: begin
                state_next = IDLE;
`ifdef TTY_SCROLL_EN
                if (newline && last_row) state_next = CLEAR;
`endif
            end
`ifdef TTY_SCROLL_EN
            CLEAR: if (clear_last) state_next = IDLE;
`endif
            default: state_next = IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    // Address and data are forced to 0 whenever no write is issued, which
    // also gives the all-zero output state right after reset.
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves one unassigned (no latch).
        fifo_pop = 1'b0;
        ttywrite = 1'b0;
        wr_row   = '0;
        wr_col   = '0;
        ttydata  = '0;
        case (state)
            IDLE: fifo_pop = !fifo_empty;
            EXEC: begin
                if (cmd == CMD_PRINT) begin
                    ttywrite = 1'b1;
                    wr_row   = cur_phys;
                    wr_col   = cur_x;
                    ttydata  = char_q;
                end else if (cmd == CMD_BS) begin
                    ttywrite = 1'b1;
                    wr_row   = cur_phys;
                    wr_col   = cur_x - 7'd1;
                    ttydata  = CH_SPACE;
                end
            end
`ifdef TTY_SCROLL_EN
            CLEAR: begin
                ttywrite = 1'b1;
                wr_row   = scroll_row;
                wr_col   = clear_col;
                ttydata  = CH_SPACE;
            end
`endif
            default: ;
        endcase
    end

    assign ttyaddr = 12'(wr_row) * 12'(COLS) + 12'(wr_col);

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk_50mhz) begin
        if (!rst_n) begin
            char_q <= '0;
            cur_x  <= '0;
            cur_y  <= '0;
        end else begin
            if (fifo_pop) char_q <= fifo_dout;
            if (state == EXEC) begin
                case (cmd)
                    CMD_PRINT: cur_x <= (cur_x == 7'(COLS-1)) ? '0 : cur_x + 7'd1;
                    CMD_LF,
                    CMD_CR:    cur_x <= '0;
                    CMD_BS:    cur_x <= cur_x - 7'd1;
                    default:   ;
                endcase
                if (newline) begin
                    if (!last_row) cur_y <= cur_y + 5'd1;
`ifndef TTY_SCROLL_EN
                    else           cur_y <= '0;
`endif
                end
            end
        end
    end

`ifdef TTY_SCROLL_EN
    // Clearing walks the top physical row, then that row becomes the bottom
    // logical row by advancing scroll_row; cur_y stays on the last row.
    always_ff @(posedge clk_50mhz) begin
        if (!rst_n) begin
            clear_col  <= '0;
            scroll_row <= '0;
        end else if (state == CLEAR) begin
            if (clear_last) begin
                clear_col  <= '0;
                scroll_row <= (scroll_row == 5'(ROWS-1)) ? '0 : scroll_row + 5'd1;
            end else begin
                clear_col <= clear_col + 7'd1;
            end
        end
    end
`else
    assign scroll_row = '0;
`endif

endmodule
